mem_arbiter: RTL and testbench

//  Parametrised multi-port memory block for the Raisin64 core. It replaces the

---
 rtl/mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin multi-port front end to a single word-wide RAM with valid/ready requests,
// byte-enabled writes, out-of-range flagging and configurable wait states.
module mem_arbiter #(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned NUM_BYTES   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*DATA_W/8-1:0] req_be,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic                          resp_err,
    output logic [DATA_W-1:0]             resp_rdata
);

    localparam int unsigned NB        = DATA_W / 8;
    localparam int unsigned OFF       = $clog2(NB);
    localparam int unsigned NUM_WORDS = NUM_BYTES / NB;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PTR_W-1:0]     ptr_q, port_q, gnt_idx;
    logic                 gnt_any;
    logic                 accept, enter_resp;

    logic [ADDR_W-1:0]    addr_q, txn_addr;
    logic                 we_q, txn_we;
    logic [NB-1:0]        be_q, txn_be;
    logic [DATA_W-1:0]    wdata_q, txn_wdata;

    logic                 in_range;
    logic [IDX_W-1:0]     word_idx;
    logic [DATA_W-1:0]    cur_word, new_word;
    logic [DATA_W-1:0]    mem [NUM_WORDS];

    logic [NUM_PORTS-1:0] resp_valid_q;
    logic                 resp_err_q;
    logic [DATA_W-1:0]    resp_rdata_q;

    // First requester after the pointer, wrapping around.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            cand = (32'(ptr_q) + i) % NUM_PORTS;
            if (!gnt_any && req_valid[PTR_W'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(cand);
            end
        end
    end

    // With no wait states the RAM is touched on the accept edge, so bypass the latches.
    always_comb begin
        if (state_q == StIdle) begin
            txn_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
            txn_we    = req_we[gnt_idx];
            txn_be    = req_be[gnt_idx*NB +: NB];
            txn_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
        end else begin
            txn_addr  = addr_q;
            txn_we    = we_q;
            txn_be    = be_q;
            txn_wdata = wdata_q;
        end
    end

    always_comb begin
        in_range = (txn_addr < ADDR_W'(NUM_BYTES));
        word_idx = txn_addr[OFF +: IDX_W];
        cur_word = mem[word_idx];
        for (int unsigned b = 0; b < NB; b++) begin
            new_word[b*8 +: 8] = (txn_we && txn_be[b]) ? txn_wdata[b*8 +: 8] : cur_word[b*8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            StIdle: begin
                if (gnt_any && !rst) begin
                    req_ready[gnt_idx] = 1'b1;
                    accept             = 1'b1;
                    cnt_d              = '0;
                    if (WAIT_STATES == 0) begin
                        state_d    = StResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == CNT_W'(WAIT_STATES - 1)) begin
                    state_d    = StResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ptr_q        <= PTR_W'(NUM_PORTS - 1);
            port_q       <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            resp_valid_q <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ptr_q   <= gnt_idx;
                port_q  <= gnt_idx;
                addr_q  <= txn_addr;
                we_q    <= txn_we;
                be_q    <= txn_be;
                wdata_q <= txn_wdata;
            end
            if (enter_resp) begin
                resp_err_q   <= !in_range;
                resp_rdata_q <= in_range ? new_word : '0;
            end
            resp_valid_q <= (state_q == StResp) ? (NUM_PORTS'(1) << port_q) : '0;
        end
    end

    // RAM contents survive reset; enter_resp is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (enter_resp && in_range && txn_we) begin
            mem[word_idx] <= new_word;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives two mem_arbiter instances (0 and 3 wait states) from shared clock/reset and checks
// them against a transaction-level model of the arbitration, latency and byte memory.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]   valid [2];
    logic [1:0]   ready [2];
    logic [1:0]   we    [2];
    logic [127:0] addr  [2];
    logic [15:0]  be    [2];
    logic [127:0] wdata [2];
    logic [1:0]   rvalid[2];
    logic         err   [2];
    logic [63:0]  rdata [2];

    mem_arbiter #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64), .NUM_BYTES(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(ready[0]), .req_addr(addr[0]),
        .req_we(we[0]), .req_be(be[0]), .req_wdata(wdata[0]), .resp_valid(rvalid[0]),
        .resp_err(err[0]), .resp_rdata(rdata[0])
    );

    mem_arbiter #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64), .NUM_BYTES(256), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(ready[1]), .req_addr(addr[1]),
        .req_we(we[1]), .req_be(be[1]), .req_wdata(wdata[1]), .resp_valid(rvalid[1]),
        .resp_err(err[1]), .resp_rdata(rdata[1])
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requester slots: a request stays posted until the model says it was granted.
    logic        s_has [2][2];
    logic        s_we  [2][2];
    logic [63:0] s_addr[2][2];
    logic [7:0]  s_be  [2][2];
    logic [63:0] s_wd  [2][2];

    // Reference model state.
    logic [7:0]  mref [2][256];
    int          ptr [2];
    int          busy_until [2];
    logic        pend_v [2];
    int          pend_due [2];
    int          pend_port [2];
    logic        pend_we [2];
    logic [63:0] pend_addr [2];
    logic [7:0]  pend_be [2];
    logic [63:0] pend_wd [2];
    int          gnt_log [2][$];

    logic rst_req = 1'b1;
    logic rand_mode = 1'b0;
    logic contend = 1'b0;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic new_req(input int d, input int p, input logic read_only);
        s_has[d][p] = 1'b1;
        s_we[d][p]  = read_only ? 1'b0 : 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0)
            s_addr[d][p] = ($urandom_range(0, 1) == 1) ? 64'(256 + $urandom_range(0, 255))
                                                       : {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        else
            s_addr[d][p] = 64'($urandom_range(0, 255));
        s_be[d][p] = 8'($urandom);
        s_wd[d][p] = {$urandom, $urandom};
    endtask

    task automatic post(input int d, input int p, input logic w, input logic [63:0] a,
                        input logic [7:0] b, input logic [63:0] v);
        s_has[d][p] = 1'b1;
        s_we[d][p]  = w;
        s_addr[d][p] = a;
        s_be[d][p]  = b;
        s_wd[d][p]  = v;
    endtask

    task automatic step();
        logic [1:0]  exp_rv, exp_rdy;
        logic        e_err;
        logic [63:0] e_rd;
        int          base, g;
        @(negedge clk);
        rst = rst_req;
        for (int d = 0; d < 2; d++) begin
            if (rst_req) begin
                pend_v[d] = 1'b0;
                ptr[d] = 1;
                busy_until[d] = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (rand_mode) begin
                    if (s_has[d][p]) begin
                        if ($urandom_range(0, 7) == 0) s_has[d][p] = 1'b0;
                    end else if ($urandom_range(0, 1) == 1) begin
                        new_req(d, p, 1'b0);
                    end
                end else if (contend && !s_has[d][p]) begin
                    new_req(d, p, 1'b1);
                end
                valid[d][p] = s_has[d][p];
                we[d][p] = s_we[d][p];
                addr[d][p*64 +: 64] = s_addr[d][p];
                be[d][p*8 +: 8] = s_be[d][p];
                wdata[d][p*64 +: 64] = s_wd[d][p];
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_rv = '0;
            if (rst_req) begin
                check_eq($sformatf("d%0d reset resp_err", d), 64'(err[d]), 64'(0));
                check_eq($sformatf("d%0d reset resp_rdata", d), rdata[d], 64'(0));
            end
            if (pend_v[d] && cyc == pend_due[d]) begin
                exp_rv[pend_port[d]] = 1'b1;
                e_rd = '0;
                if (pend_addr[d] >= 64'd256) begin
                    e_err = 1'b1;
                end else begin
                    e_err = 1'b0;
                    base = int'(pend_addr[d][7:3]) * 8;
                    for (int b = 0; b < 8; b++) begin
                        if (pend_we[d] && pend_be[d][b]) mref[d][base+b] = pend_wd[d][b*8 +: 8];
                        e_rd[b*8 +: 8] = mref[d][base+b];
                    end
                end
                check_eq($sformatf("d%0d resp_err", d), 64'(err[d]), 64'(e_err));
                check_eq($sformatf("d%0d resp_rdata", d), rdata[d], e_rd);
                pend_v[d] = 1'b0;
            end
            check_eq($sformatf("d%0d resp_valid", d), 64'(rvalid[d]), 64'(exp_rv));

            exp_rdy = '0;
            g = -1;
            if (!rst_req && cyc >= busy_until[d]) begin
                for (int k = 1; k <= 2; k++) begin
                    if (g < 0 && s_has[d][(ptr[d] + k) % 2]) g = (ptr[d] + k) % 2;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check_eq($sformatf("d%0d req_ready", d), 64'(ready[d]), 64'(exp_rdy));
            if (ready[d] != 2'b00) gnt_log[d].push_back(ready[d][1] ? 1 : 0);
            if (g >= 0) begin
                pend_v[d] = 1'b1;
                pend_due[d] = cyc + 2 + ws(d);
                busy_until[d] = cyc + 2 + ws(d);
                pend_port[d] = g;
                pend_we[d] = s_we[d][g];
                pend_addr[d] = s_addr[d][g];
                pend_be[d] = s_be[d][g];
                pend_wd[d] = s_wd[d][g];
                ptr[d] = g;
                s_has[d][g] = 1'b0;
            end
        end
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((pend_v[0] || pend_v[1] || s_has[0][0] || s_has[0][1] || s_has[1][0] ||
                s_has[1][1]) && n < max) begin
            step();
            n++;
        end
        check_eq("drain bound", 64'(n < max), 64'(1));
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            valid[d] = '0; we[d] = '0; addr[d] = '0; be[d] = '0; wdata[d] = '0;
            pend_v[d] = 1'b0; ptr[d] = 1; busy_until[d] = 0;
            for (int p = 0; p < 2; p++) begin
                s_has[d][p] = 1'b0; s_we[d][p] = 1'b0; s_addr[d][p] = '0;
                s_be[d][p] = '0; s_wd[d][p] = '0;
            end
        end
        do_reset();

        // Give every RAM word a known value.
        for (int w = 0; w < 32; w++) begin
            post(0, 0, 1'b1, 64'(w * 8), 8'hFF, {$urandom, $urandom});
            post(1, 0, 1'b1, 64'(w * 8), 8'hFF, {$urandom, $urandom});
            run_until_idle(20);
        end

        // Full-word write then read, then a single-byte-lane write.
        for (int d = 0; d < 2; d++) begin
            post(d, 0, 1'b1, 64'h08, 8'hFF, 64'h1122_3344_5566_7788);
            run_until_idle(20);
            post(d, 0, 1'b0, 64'h08, 8'h00, 64'h0);
            run_until_idle(20);
            post(d, 0, 1'b1, 64'h08, 8'hFF, 64'h0);
            run_until_idle(20);
            post(d, 1, 1'b1, 64'h0F, 8'h01, 64'h5A5A_5A5A_5A5A_5AAB);
            run_until_idle(20);
            post(d, 1, 1'b0, 64'h08, 8'h00, 64'h0);
            run_until_idle(20);
        end

        // Out-of-range reads and writes, then read back the whole RAM.
        for (int d = 0; d < 2; d++) begin
            post(d, 0, 1'b0, 64'h100, 8'h00, 64'h0);
            run_until_idle(20);
            post(d, 1, 1'b1, 64'h100, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
            run_until_idle(20);
            post(d, 0, 1'b1, 64'hFFFF_0000_0000_0010, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
            run_until_idle(20);
        end
        for (int w = 0; w < 32; w++) begin
            post(0, w % 2, 1'b0, 64'(w * 8), 8'h00, 64'h0);
            post(1, w % 2, 1'b0, 64'(w * 8), 8'h00, 64'h0);
            run_until_idle(20);
        end

        // Continuous contention straight out of reset.
        do_reset();
        gnt_log[0].delete();
        gnt_log[1].delete();
        contend = 1'b1;
        n = 0;
        while ((gnt_log[0].size() < 8 || gnt_log[1].size() < 8) && n < 200) begin
            step();
            n++;
        end
        contend = 1'b0;
        run_until_idle(40);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d grant count", d), 64'(gnt_log[d].size() >= 8), 64'(1));
            for (int k = 0; k < 8 && k < gnt_log[d].size(); k++)
                check_eq($sformatf("d%0d grant order %0d", d, k), 64'(gnt_log[d][k]), 64'(k % 2));
        end

        // Reset in the wait phase of a write on the wait-state instance.
        post(1, 0, 1'b0, 64'h18, 8'h00, 64'h0);
        run_until_idle(20);
        post(1, 0, 1'b1, 64'h10, 8'hFF, 64'hCAFE_F00D_CAFE_F00D);
        n = 0;
        while (!pend_v[1] && n < 20) begin
            step();
            n++;
        end
        check_eq("abort write accepted", 64'(pend_v[1]), 64'(1));
        step();
        do_reset();
        gnt_log[1].delete();
        post(1, 0, 1'b0, 64'h10, 8'h00, 64'h0);
        post(1, 1, 1'b0, 64'h18, 8'h00, 64'h0);
        run_until_idle(30);
        check_eq("post reset grant count", 64'(gnt_log[1].size()), 64'(2));
        if (gnt_log[1].size() > 0)
            check_eq("post reset first grant", 64'(gnt_log[1][0]), 64'(0));

        // Randomized traffic with withdrawals.
        rand_mode = 1'b1;
        repeat (1500) step();
        rand_mode = 1'b0;
        run_until_idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
